// File: rtl/cpu_sequencer_if.sv
// Memory and ALU side-band bus of the accumulator CPU sequencer.
// master = sequencer, slave = memory/ALU datapath.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 5
);
  // Strobe semantics: every strobe is a one-cycle level decoded from the
  // sequencer state; there is no back-pressure, memory answers in the same cycle.
  logic [ADDR_W-1:0] addr;
  logic              mem_rd;
  logic              mem_we;
  logic [7:0]        d_bus_in;
  logic [7:0]        instruction;
  logic              ldAcc;
  logic              useAlu;
  logic              dbusSelect;
  logic              z;

  modport master (
    output addr, mem_rd, mem_we, instruction, ldAcc, useAlu, dbusSelect,
    input  d_bus_in, z
  );

  modport slave (
    input  addr, mem_rd, mem_we, instruction, ldAcc, useAlu, dbusSelect,
    output d_bus_in, z
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU (IR, PC, strobes).
// Optional single-step input enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  cpu_sequencer_if.master     bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC_A = 2'd2,
    EXEC_B = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NAND  = 3'b010,
    OP_SHIFT = 3'b011,
    OP_LD    = 3'b100,
    OP_ST    = 3'b101,
    OP_JMP   = 3'b110,
    OP_JZ    = 3'b111
  } opcode_t;

  state_t            state_q, state_d;
  logic [7:0]        ir_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ir_load;
  logic [ADDR_W-1:0] operand;
  logic [2:0]        opcode;

  logic [ADDR_W-1:0] addr_c;
  logic              mem_rd_c, mem_we_c, ld_acc_c, use_alu_c, dbus_sel_c;

  assign opcode  = ir_q[7:5];
  assign operand = ir_q[ADDR_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
  // step is synchronised first; only a fresh 0->1 transition launches an instruction
  logic step_q1, step_q2, step_rise;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q1 <= 1'b0;
      step_q2 <= 1'b0;
    end else begin
      step_q1 <= step;
      step_q2 <= step_q1;
    end
  end
  assign step_rise = step_q1 & ~step_q2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= 8'h00;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ir_load) ir_q <= bus.d_bus_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_load    = 1'b0;
    addr_c     = pc_q;
    mem_rd_c   = 1'b0;
    mem_we_c   = 1'b0;
    ld_acc_c   = 1'b0;
    use_alu_c  = 1'b0;
    dbus_sel_c = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (run || step_rise) state_d = FETCH;
`else
        if (run) state_d = FETCH;
`endif
      end
      FETCH: begin
        mem_rd_c = 1'b1;
        ir_load  = 1'b1;
        pc_d     = pc_q + ADDR_W'(1);
        state_d  = EXEC_A;
      end
      EXEC_A: begin
        addr_c  = operand;
        state_d = run ? FETCH : IDLE;
        // Unlisted or unknown opcodes fall to default: no strobes, normal exit
        case (opcode)
          OP_ADD, OP_SUB, OP_NAND: begin
            mem_rd_c  = 1'b1;
            use_alu_c = 1'b1;
          end
          OP_SHIFT: use_alu_c = 1'b1;
          OP_LD: begin
            mem_rd_c = 1'b1;
            ld_acc_c = 1'b1;
          end
          OP_ST:  state_d = EXEC_B;
          OP_JMP: pc_d = operand;
          OP_JZ:  if (bus.z) pc_d = operand;
          default: ;
        endcase
      end
      EXEC_B: begin
        addr_c     = operand;
        dbus_sel_c = 1'b1;
        mem_we_c   = 1'b1;
        state_d    = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.addr        = addr_c;
  assign bus.mem_rd      = mem_rd_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.ldAcc       = ld_acc_c;
  assign bus.useAlu      = use_alu_c;
  assign bus.dbusSelect  = dbus_sel_c;
  assign bus.instruction = ir_q;
  assign pc              = pc_q;
  assign busy            = (state_q != IDLE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle vector table plus
// hand-written JMP-wrap and reset-during-store sequences.
module tb_cpu_sequencer;
  localparam int W = 26;

  logic       clk;
  logic       reset;
  logic       run;
  logic       z;
  logic [4:0] pc;
  logic       busy;
  logic [1:0] dbg_state;
  logic [7:0] mem [32];

  cpu_sequencer_if #(.ADDR_W(5)) bus ();

  assign bus.d_bus_in = mem[bus.addr];
  assign bus.z        = z;

  cpu_sequencer #(.ADDR_W(5), .RESET_PC(5'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe groups {mem_rd, mem_we, ldAcc, useAlu, dbusSelect, busy}
  localparam logic [5:0] S_IDLE   = 6'b000000;
  localparam logic [5:0] S_RD     = 6'b100001;
  localparam logic [5:0] S_LD     = 6'b101001;
  localparam logic [5:0] S_ALU_RD = 6'b100101;
  localparam logic [5:0] S_ALU    = 6'b000101;
  localparam logic [5:0] S_NONE   = 6'b000001;
  localparam logic [5:0] S_WR     = 6'b010011;

  typedef struct {
    logic         run;
    logic [1:0]   zsel;   // 0/1 drive that value, 2 = random
    logic [W-1:0] exp;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  vec_t         vecs [23];

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [7:0] ir,
                                      input logic [4:0] a, input logic [4:0] p,
                                      input logic [5:0] s);
    return {st, ir, a, p, s};
  endfunction

  function automatic logic [W-1:0] observe();
    return {dbg_state, bus.instruction, bus.addr, pc, bus.mem_rd, bus.mem_we,
            bus.ldAcc, bus.useAlu, bus.dbusSelect, busy};
  endfunction

  // scoreboard: pop the oldest expectation and compare with current outputs
  task automatic compare_now(input string nm);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = observe();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d ir=%h addr=%0d pc=%0d strb=%b, expected st=%0d ir=%h addr=%0d pc=%0d strb=%b",
                 nm, got[25:24], got[23:16], got[15:11], got[10:6], got[5:0],
                 e[25:24], e[23:16], e[15:11], e[10:6], e[5:0]);
      end
    end
  endtask

  // driver: apply one cycle's inputs, check at negedge, advance past posedge
  task automatic drive_cycle(input logic r, input logic [1:0] zsel,
                             input logic [W-1:0] e, input string nm);
    run = r;
    z   = (zsel == 2'd2) ? 1'($urandom_range(0, 1)) : zsel[0];
    exp_q.push_back(e);
    @(negedge clk);
    compare_now(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string nm);
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back(mk(2'd0, 8'h00, 5'd0, 5'd0, S_IDLE));
    @(negedge clk);
    compare_now(nm);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    z     = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h85;  // LD 5
    mem[1] = 8'h06;  // ADD 6
    mem[2] = 8'h60;  // SHIFT
    mem[3] = 8'hAA;  // ST 10
    mem[4] = 8'hE3;  // JZ 3 (z=0)
    mem[5] = 8'h9E;  // LD operand, fetched later as LD 30
    mem[6] = 8'h61;  // ADD operand, fetched later as SHIFT
    mem[7] = 8'hE3;  // JZ 3 (z=1)

    vecs[0]  = '{1'b1, 2'd2, mk(2'd0, 8'h00, 5'd0,  5'd0, S_IDLE)};
    vecs[1]  = '{1'b1, 2'd2, mk(2'd1, 8'h00, 5'd0,  5'd0, S_RD)};
    vecs[2]  = '{1'b1, 2'd2, mk(2'd2, 8'h85, 5'd5,  5'd1, S_LD)};
    vecs[3]  = '{1'b1, 2'd2, mk(2'd1, 8'h85, 5'd1,  5'd1, S_RD)};
    vecs[4]  = '{1'b1, 2'd2, mk(2'd2, 8'h06, 5'd6,  5'd2, S_ALU_RD)};
    vecs[5]  = '{1'b1, 2'd2, mk(2'd1, 8'h06, 5'd2,  5'd2, S_RD)};
    vecs[6]  = '{1'b1, 2'd2, mk(2'd2, 8'h60, 5'd0,  5'd3, S_ALU)};
    vecs[7]  = '{1'b1, 2'd2, mk(2'd1, 8'h60, 5'd3,  5'd3, S_RD)};
    vecs[8]  = '{1'b1, 2'd2, mk(2'd2, 8'hAA, 5'd10, 5'd4, S_NONE)};
    vecs[9]  = '{1'b1, 2'd2, mk(2'd3, 8'hAA, 5'd10, 5'd4, S_WR)};
    vecs[10] = '{1'b1, 2'd2, mk(2'd1, 8'hAA, 5'd4,  5'd4, S_RD)};
    vecs[11] = '{1'b1, 2'd0, mk(2'd2, 8'hE3, 5'd3,  5'd5, S_NONE)};
    vecs[12] = '{1'b1, 2'd2, mk(2'd1, 8'hE3, 5'd5,  5'd5, S_RD)};
    vecs[13] = '{1'b1, 2'd2, mk(2'd2, 8'h9E, 5'd30, 5'd6, S_LD)};
    vecs[14] = '{1'b1, 2'd2, mk(2'd1, 8'h9E, 5'd6,  5'd6, S_RD)};
    vecs[15] = '{1'b1, 2'd2, mk(2'd2, 8'h61, 5'd1,  5'd7, S_ALU)};
    vecs[16] = '{1'b1, 2'd2, mk(2'd1, 8'h61, 5'd7,  5'd7, S_RD)};
    vecs[17] = '{1'b1, 2'd1, mk(2'd2, 8'hE3, 5'd3,  5'd8, S_NONE)};
    vecs[18] = '{1'b1, 2'd2, mk(2'd1, 8'hE3, 5'd3,  5'd3, S_RD)};
    vecs[19] = '{1'b0, 2'd2, mk(2'd2, 8'hAA, 5'd10, 5'd4, S_NONE)};
    vecs[20] = '{1'b0, 2'd2, mk(2'd3, 8'hAA, 5'd10, 5'd4, S_WR)};
    vecs[21] = '{1'b0, 2'd2, mk(2'd0, 8'hAA, 5'd4,  5'd4, S_IDLE)};
    vecs[22] = '{1'b0, 2'd2, mk(2'd0, 8'hAA, 5'd4,  5'd4, S_IDLE)};

    apply_reset("reset_state");
    for (int i = 0; i < 23; i++)
      drive_cycle(vecs[i].run, vecs[i].zsel, vecs[i].exp, $sformatf("prog_c%0d", i));

    // JMP to 31, fetch at 31 wraps pc to 0, then JMP 0
    mem[0]  = 8'hDF;
    mem[31] = 8'hC0;
    apply_reset("reset_jmp");
    drive_cycle(1'b1, 2'd2, mk(2'd0, 8'h00, 5'd0,  5'd0,  S_IDLE), "jmp_c0");
    drive_cycle(1'b1, 2'd2, mk(2'd1, 8'h00, 5'd0,  5'd0,  S_RD),   "jmp_c1");
    drive_cycle(1'b1, 2'd2, mk(2'd2, 8'hDF, 5'd31, 5'd1,  S_NONE), "jmp_c2");
    drive_cycle(1'b1, 2'd2, mk(2'd1, 8'hDF, 5'd31, 5'd31, S_RD),   "jmp_fetch31");
    drive_cycle(1'b1, 2'd2, mk(2'd2, 8'hC0, 5'd0,  5'd0,  S_NONE), "jmp_wrap");
    drive_cycle(1'b1, 2'd2, mk(2'd1, 8'hC0, 5'd0,  5'd0,  S_RD),   "jmp_c5");
    drive_cycle(1'b0, 2'd2, mk(2'd2, 8'hDF, 5'd31, 5'd1,  S_NONE), "jmp_c6");
    drive_cycle(1'b0, 2'd2, mk(2'd0, 8'hDF, 5'd31, 5'd31, S_IDLE), "jmp_idle");

    // asynchronous reset in the middle of the store's write cycle
    mem[0] = 8'hAA;
    apply_reset("reset_st");
    drive_cycle(1'b1, 2'd2, mk(2'd0, 8'h00, 5'd0,  5'd0, S_IDLE), "st_c0");
    drive_cycle(1'b1, 2'd2, mk(2'd1, 8'h00, 5'd0,  5'd0, S_RD),   "st_c1");
    drive_cycle(1'b1, 2'd2, mk(2'd2, 8'hAA, 5'd10, 5'd1, S_NONE), "st_c2");
    #2;
    exp_q.push_back(mk(2'd3, 8'hAA, 5'd10, 5'd1, S_WR));
    compare_now("st_exec_b");
    reset = 1'b0;
    #1;
    exp_q.push_back(mk(2'd0, 8'h00, 5'd0, 5'd0, S_IDLE));
    compare_now("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(mk(2'd0, 8'h00, 5'd0, 5'd0, S_IDLE));
    compare_now("held_reset");
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // strobe exclusivity is checked every cycle as well
  always @(negedge clk) begin
    if (reset) begin
      if ((int'(bus.ldAcc) + int'(bus.useAlu) + int'(bus.dbusSelect)) > 1 ||
          (bus.mem_rd && bus.mem_we)) begin
        n_checks++;
        n_fail++;
        $display("FAIL strobe_excl: ld=%b alu=%b dsel=%b rd=%b we=%b, at most one ALU strobe and not rd&we",
                 bus.ldAcc, bus.useAlu, bus.dbusSelect, bus.mem_rd, bus.mem_we);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end
endmodule
